// File: rtl/axi_addr_remap_reg_pkg.sv
// rtl/axi_addr_remap_reg_pkg.sv - default AXI channel/request/response types and the remap rule-type macro
// Integrators with their own AXI types build a matching rule struct with the macro below.

`define AXI_TYPEDEF_ADDR_REMAP_RULE_T(name, slv_addr_t, mst_addr_t) \
  typedef struct packed {                                             \
    slv_addr_t start_addr;                                            \
    slv_addr_t end_addr;                                              \
    mst_addr_t mst_base;                                              \
  } name;

package axi_addr_remap_reg_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } remap_aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } remap_ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } remap_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } remap_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } remap_r_chan_t;

  typedef struct packed {
    remap_aw_chan_t aw;
    logic           aw_valid;
    remap_w_chan_t  w;
    logic           w_valid;
    logic           b_ready;
    remap_ar_chan_t ar;
    logic           ar_valid;
    logic           r_ready;
  } remap_req_t;

  typedef struct packed {
    logic          aw_ready;
    logic          ar_ready;
    logic          w_ready;
    logic          b_valid;
    remap_b_chan_t b;
    logic          r_valid;
    remap_r_chan_t r;
  } remap_rsp_t;

  `AXI_TYPEDEF_ADDR_REMAP_RULE_T(remap_rule_t, logic [31:0], logic [31:0])

endpackage

// File: rtl/axi_addr_remap_slot.sv
// rtl/axi_addr_remap_slot.sv - one-entry register slot with rule-table address translation
// Translation is evaluated on the incoming address and frozen into the slot at accept.

module axi_addr_remap_slot
  import axi_addr_remap_reg_pkg::*;
#(
  parameter int unsigned NumRules     = 1,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32,
  parameter type         rule_t       = remap_rule_t,
  parameter type         chan_t       = remap_aw_chan_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  rule_t [NumRules-1:0]    rules_i,
  input  chan_t                   slv_chan,
  input  logic [SlvAddrWidth-1:0] slv_addr,
  input  logic                    slv_valid,
  output logic                    slv_ready,
  output chan_t                   mst_chan,
  output logic                    mst_valid,
  input  logic                    mst_ready,
  output logic [MstAddrWidth-1:0] mst_addr,
  output logic                    miss
);

  logic                    full_q;
  logic                    accept;
  logic                    hit;
  logic [SlvAddrWidth-1:0] offset;
  logic [MstAddrWidth-1:0] xlat;

  // Empty or inverted ranges fall out of the compare naturally; first hit wins.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    xlat   = MstAddrWidth'(slv_addr);
    for (int i = 0; i < int'(NumRules); i++) begin
      if (!hit && (slv_addr >= rules_i[i].start_addr) && (slv_addr < rules_i[i].end_addr)) begin
        hit    = 1'b1;
        offset = slv_addr - rules_i[i].start_addr;
        xlat   = rules_i[i].mst_base + MstAddrWidth'(offset);
      end
    end
  end

  assign slv_ready = !full_q || mst_ready;
  assign accept    = slv_valid && slv_ready;
  assign mst_valid = full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q   <= 1'b0;
      mst_chan <= '0;
      mst_addr <= '0;
      miss     <= 1'b0;
    end else begin
      if (accept) begin
        full_q   <= 1'b1;
        mst_chan <= slv_chan;
        mst_addr <= xlat;
        miss     <= !hit;
      end else if (mst_ready) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_addr_remap_reg.sv
// rtl/axi_addr_remap_reg.sv - registered AW/AR address remap stage with W/B/R passthrough
// Held AW/AR beats keep their translated address stable until the downstream handshake.

module axi_addr_remap_reg
  import axi_addr_remap_reg_pkg::*;
#(
  parameter int unsigned NumRules     = 1,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32,
  parameter type         rule_t       = remap_rule_t,
  parameter type         aw_chan_t    = remap_aw_chan_t,
  parameter type         ar_chan_t    = remap_ar_chan_t,
  parameter type         axi_req_t    = remap_req_t,
  parameter type         axi_rsp_t    = remap_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  rule_t [NumRules-1:0]    rules_i,
  input  axi_req_t                slv_req_i,
  output axi_rsp_t                slv_resp_o,
  output axi_req_t                mst_req_o,
  input  axi_rsp_t                mst_resp_i,
  output logic [MstAddrWidth-1:0] mst_aw_addr_o,
  output logic [MstAddrWidth-1:0] mst_ar_addr_o,
  output logic                    aw_miss_o,
  output logic                    ar_miss_o
);

  logic [SlvAddrWidth-1:0] aw_addr;
  logic [SlvAddrWidth-1:0] ar_addr;
  aw_chan_t                aw_q;
  ar_chan_t                ar_q;
  logic                    aw_valid_q;
  logic                    ar_valid_q;
  logic                    aw_ready;
  logic                    ar_ready;

  assign aw_addr = SlvAddrWidth'(slv_req_i.aw.addr);
  assign ar_addr = SlvAddrWidth'(slv_req_i.ar.addr);

  axi_addr_remap_slot #(
    .NumRules     (NumRules),
    .SlvAddrWidth (SlvAddrWidth),
    .MstAddrWidth (MstAddrWidth),
    .rule_t       (rule_t),
    .chan_t       (aw_chan_t)
  ) u_aw_slot (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rules_i   (rules_i),
    .slv_chan  (slv_req_i.aw),
    .slv_addr  (aw_addr),
    .slv_valid (slv_req_i.aw_valid),
    .slv_ready (aw_ready),
    .mst_chan  (aw_q),
    .mst_valid (aw_valid_q),
    .mst_ready (mst_resp_i.aw_ready),
    .mst_addr  (mst_aw_addr_o),
    .miss      (aw_miss_o)
  );

  axi_addr_remap_slot #(
    .NumRules     (NumRules),
    .SlvAddrWidth (SlvAddrWidth),
    .MstAddrWidth (MstAddrWidth),
    .rule_t       (rule_t),
    .chan_t       (ar_chan_t)
  ) u_ar_slot (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rules_i   (rules_i),
    .slv_chan  (slv_req_i.ar),
    .slv_addr  (ar_addr),
    .slv_valid (slv_req_i.ar_valid),
    .slv_ready (ar_ready),
    .mst_chan  (ar_q),
    .mst_valid (ar_valid_q),
    .mst_ready (mst_resp_i.ar_ready),
    .mst_addr  (mst_ar_addr_o),
    .miss      (ar_miss_o)
  );

  // W, B-ready and R-ready flow straight through; AW/AR come from the slots.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_q;
    mst_req_o.aw_valid = aw_valid_q;
    mst_req_o.ar       = ar_q;
    mst_req_o.ar_valid = ar_valid_q;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
  end

endmodule
